// File: rtl/cmd_file_loader.sv
// TRS-80 /CMD parser: one byte per ioctl_wr strobe, RAM write registered one cycle later, no backpressure.
// CMD_FILE_LOADER_EXEC_EN enables the post-load execute_enable pulse; otherwise the image only loads.
module cmd_file_loader #(
  parameter logic [7:0] CMD_INDEX   = 8'd1,
  parameter int         EXEC_CYCLES = 16
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [7:0]  ioctl_dout,
  output logic        loader_wr,
  output logic [15:0] loader_addr,
  output logic [7:0]  loader_data,
  output logic        loader_busy,
  output logic        loader_error,
  output logic [15:0] execute_addr,
  output logic        execute_enable
);

  typedef enum logic [3:0] {
    S_IDLE, S_TYPE, S_LEN, S_ADDR_LO, S_ADDR_HI, S_DATA,
    S_XFER_LO, S_XFER_HI, S_SKIP, S_DONE
`ifdef CMD_FILE_LOADER_EXEC_EN
    , S_EXEC
`endif
  } state_t;

  state_t      state, st_after;
  logic [7:0]  rec_type;
  logic [8:0]  cnt;
  logic [15:0] load_addr;
  logic        xfer_seen, xs_after, err_after;
  logic        to_done;
  logic        sel;
  logic        dl_q;
  logic        dl_rise, dl_fall, consume, end_ok;
  logic [7:0]  len_m2;

`ifdef CMD_FILE_LOADER_EXEC_EN
  logic [7:0]  exec_cnt;
  logic        exec_en_q;
  assign execute_enable = exec_en_q;
`else
  assign execute_enable = 1'b0;
`endif

  assign dl_rise = ioctl_download & ~dl_q & (ioctl_index == CMD_INDEX);
  assign dl_fall = ~ioctl_download & dl_q & sel;
  assign consume = sel & ioctl_wr;
  assign len_m2  = ioctl_dout - 8'd2;
  assign end_ok  = xs_after & ~err_after & ((st_after == S_TYPE) || (st_after == S_DONE));

  // Parser state after consuming this cycle's byte; end-of-download checks look at this.
  always_comb begin
    st_after  = state;
    xs_after  = xfer_seen;
    err_after = loader_error;
    if (consume) begin
      case (state)
        S_TYPE:    st_after = S_LEN;
        S_LEN: begin
          if (rec_type == 8'h01) st_after = S_ADDR_LO;
          else if (rec_type == 8'h02) begin
            st_after = S_XFER_LO;
            if (ioctl_dout == 8'd1) err_after = 1'b1;
          end else st_after = S_SKIP;
        end
        S_ADDR_LO: st_after = S_ADDR_HI;
        S_ADDR_HI: st_after = S_DATA;
        S_DATA:    if (cnt == 9'd1) st_after = S_TYPE;
        S_XFER_LO: st_after = S_XFER_HI;
        S_XFER_HI: begin
          xs_after = 1'b1;
          st_after = (cnt > 9'd2) ? S_SKIP : S_DONE;
        end
        S_SKIP:    if (cnt == 9'd1) st_after = to_done ? S_DONE : S_TYPE;
        default:   ;
      endcase
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state        <= S_IDLE;
      rec_type     <= 8'd0;
      cnt          <= 9'd0;
      load_addr    <= 16'd0;
      xfer_seen    <= 1'b0;
      to_done      <= 1'b0;
      sel          <= 1'b0;
      dl_q         <= 1'b0;
      loader_wr    <= 1'b0;
      loader_addr  <= 16'd0;
      loader_data  <= 8'd0;
      loader_busy  <= 1'b0;
      loader_error <= 1'b0;
      execute_addr <= 16'd0;
`ifdef CMD_FILE_LOADER_EXEC_EN
      exec_cnt     <= 8'd0;
      exec_en_q    <= 1'b0;
`endif
    end else begin
      dl_q      <= ioctl_download;
      loader_wr <= 1'b0;
      if (dl_rise) begin
        state        <= S_TYPE;
        sel          <= 1'b1;
        loader_busy  <= 1'b1;
        loader_error <= 1'b0;
        xfer_seen    <= 1'b0;
`ifdef CMD_FILE_LOADER_EXEC_EN
        exec_en_q    <= 1'b0;
        exec_cnt     <= 8'd0;
`endif
      end else if (sel) begin
        if (consume) begin
          case (state)
            S_TYPE: rec_type <= ioctl_dout;
            S_LEN: begin
              if (rec_type == 8'h01)
                cnt <= (len_m2 == 8'd0) ? 9'd256 : {1'b0, len_m2};
              else
                cnt <= (ioctl_dout == 8'd0) ? 9'd256 : {1'b0, ioctl_dout};
              to_done <= (rec_type == 8'h02);
            end
            S_ADDR_LO: load_addr[7:0]  <= ioctl_dout;
            S_ADDR_HI: load_addr[15:8] <= ioctl_dout;
            S_DATA: begin
              loader_wr   <= 1'b1;
              loader_addr <= load_addr;
              loader_data <= ioctl_dout;
              load_addr   <= load_addr + 16'd1;
              cnt         <= cnt - 9'd1;
            end
            S_XFER_LO: execute_addr[7:0] <= ioctl_dout;
            S_XFER_HI: begin
              execute_addr[15:8] <= ioctl_dout;
              cnt                <= cnt - 9'd2;
            end
            S_SKIP:  cnt <= cnt - 9'd1;
            default: ;
          endcase
        end
        xfer_seen    <= xs_after;
        loader_error <= err_after;
        if (dl_fall) begin
          sel         <= 1'b0;
          loader_busy <= 1'b0;
          if ((st_after != S_TYPE) && (st_after != S_DONE)) loader_error <= 1'b1;
`ifdef CMD_FILE_LOADER_EXEC_EN
          if (end_ok) begin
            state     <= S_EXEC;
            exec_en_q <= 1'b1;
            exec_cnt  <= 8'(EXEC_CYCLES - 1);
          end else state <= S_IDLE;
`else
          state <= S_IDLE;
`endif
        end else begin
          state <= st_after;
        end
      end
`ifdef CMD_FILE_LOADER_EXEC_EN
      else if (state == S_EXEC) begin
        if (exec_cnt == 8'd0) begin
          exec_en_q <= 1'b0;
          state     <= S_IDLE;
        end else begin
          exec_cnt <= exec_cnt - 8'd1;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_cmd_file_loader.sv
// Directed bench for cmd_file_loader; execute_enable expectations follow CMD_FILE_LOADER_EXEC_EN.
module tb_cmd_file_loader;

`ifdef CMD_FILE_LOADER_EXEC_EN
  localparam bit EXEC_ON = 1'b1;
`else
  localparam bit EXEC_ON = 1'b0;
`endif

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        ioctl_download = 1'b0;
  logic [7:0]  ioctl_index = 8'd0;
  logic        ioctl_wr = 1'b0;
  logic [7:0]  ioctl_dout = 8'd0;
  logic        loader_wr;
  logic [15:0] loader_addr;
  logic [7:0]  loader_data;
  logic        loader_busy;
  logic        loader_error;
  logic [15:0] execute_addr;
  logic        execute_enable;

  int n_checks = 0;
  int n_fail   = 0;

  cmd_file_loader #(.CMD_INDEX(8'd1), .EXEC_CYCLES(16)) dut (
    .clk_sys(clk_sys), .reset(reset),
    .ioctl_download(ioctl_download), .ioctl_index(ioctl_index),
    .ioctl_wr(ioctl_wr), .ioctl_dout(ioctl_dout),
    .loader_wr(loader_wr), .loader_addr(loader_addr), .loader_data(loader_data),
    .loader_busy(loader_busy), .loader_error(loader_error),
    .execute_addr(execute_addr), .execute_enable(execute_enable)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    ioctl_wr = 1'b1; ioctl_dout = b;
    tick();
    ioctl_wr = 1'b0;
    chk("no_write", loader_wr, 1'b0);
  endtask

  task automatic send_data(input logic [7:0] b, input logic [15:0] a);
    ioctl_wr = 1'b1; ioctl_dout = b;
    tick();
    ioctl_wr = 1'b0;
    chk("wr", loader_wr, 1'b1);
    chk("wr_addr", loader_addr, a);
    chk("wr_data", loader_data, b);
  endtask

  task automatic start_dl(input logic [7:0] idx);
    ioctl_index = idx; ioctl_download = 1'b1;
    tick();
    chk("busy_start", loader_busy, idx == 8'd1);
  endtask

  task automatic end_dl();
    ioctl_download = 1'b0;
    tick();
    chk("busy_end", loader_busy, 1'b0);
  endtask

  task automatic all_reset_vals(input string tag);
    chk({tag, "_wr"}, loader_wr, 1'b0);
    chk({tag, "_addr"}, loader_addr, 16'h0);
    chk({tag, "_data"}, loader_data, 8'h0);
    chk({tag, "_busy"}, loader_busy, 1'b0);
    chk({tag, "_err"}, loader_error, 1'b0);
    chk({tag, "_xaddr"}, execute_addr, 16'h0);
    chk({tag, "_xen"}, execute_enable, 1'b0);
  endtask

  initial begin
    int n_en;
    tick(); tick();
    all_reset_vals("reset");
    reset = 1'b0;
    tick();

    // Basic image: three data bytes then transfer record
    start_dl(8'd1);
    chk("err_start", loader_error, 1'b0);
    send(8'h01); send(8'h05); send(8'h00); send(8'h52);
    send_data(8'hAA, 16'h5200);
    send_data(8'hBB, 16'h5201);
    send_data(8'hCC, 16'h5202);
    send(8'h02); send(8'h02); send(8'h00); send(8'h52);
    end_dl();
    chk("t1_err", loader_error, 1'b0);
    chk("t1_xaddr", execute_addr, 16'h5200);
    chk("t1_xen_rise", execute_enable, EXEC_ON);
    n_en = 0;
    for (int i = 0; i < 40; i++) begin
      if (execute_enable) n_en++;
      tick();
    end
    chk("t1_xen_cycles", n_en, EXEC_ON ? 16 : 0);
    chk("t1_xaddr_hold", execute_addr, 16'h5200);

    // 256-byte record (length byte 2) followed by a further record
    start_dl(8'd1);
    send(8'h01); send(8'h02); send(8'h00); send(8'h70);
    for (int i = 0; i < 256; i++) send_data(8'(i) ^ 8'h5A, 16'h7000 + 16'(i));
    send(8'h01); send(8'h03); send(8'h10); send(8'h70);
    send_data(8'hEE, 16'h7010);
    end_dl();
    chk("t2_err", loader_error, 1'b0);
    chk("t2_xen", execute_enable, 1'b0);

    // Address wrap; final byte strobed in the same cycle the download ends
    start_dl(8'd1);
    send(8'h01); send(8'h04); send(8'hFF); send(8'hFF);
    send_data(8'h11, 16'hFFFF);
    ioctl_wr = 1'b1; ioctl_dout = 8'h22; ioctl_download = 1'b0;
    tick();
    ioctl_wr = 1'b0;
    chk("t3_wr", loader_wr, 1'b1);
    chk("t3_addr", loader_addr, 16'h0000);
    chk("t3_data", loader_data, 8'h22);
    chk("t3_busy", loader_busy, 1'b0);
    chk("t3_err", loader_error, 1'b0);

    // Skipped header record, data record, transfer, then ignored trailing bytes
    start_dl(8'd1);
    send(8'h05); send(8'h03); send(8'h41); send(8'h42); send(8'h43);
    send(8'h01); send(8'h03); send(8'h00); send(8'h60);
    send_data(8'h99, 16'h6000);
    send(8'h02); send(8'h02); send(8'h34); send(8'h12);
    send(8'h01); send(8'h03); send(8'h00); send(8'h40); send(8'h77);
    end_dl();
    chk("t4_xaddr", execute_addr, 16'h1234);
    chk("t4_err", loader_error, 1'b0);
    chk("t4_xen", execute_enable, EXEC_ON);
    for (int i = 0; i < 20; i++) tick();
    chk("t4_xen_done", execute_enable, 1'b0);

    // Non-selected index leaves outputs alone
    start_dl(8'd2);
    send(8'h01); send(8'h03); send(8'h00); send(8'h40); send(8'h55);
    send(8'h02); send(8'h02); send(8'h00); send(8'h40);
    end_dl();
    chk("t5_xaddr", execute_addr, 16'h1234);
    chk("t5_waddr", loader_addr, 16'h6000);
    chk("t5_xen", execute_enable, 1'b0);

    // Truncated record flags error; next selected download clears it
    start_dl(8'd1);
    send(8'h01); send(8'h05); send(8'h00); send(8'h52);
    send_data(8'hAA, 16'h5200);
    end_dl();
    chk("t6_err", loader_error, 1'b1);
    chk("t6_xen", execute_enable, 1'b0);
    tick(); tick();
    chk("t6_err_sticky", loader_error, 1'b1);
    chk("t6_xen_late", execute_enable, 1'b0);
    start_dl(8'd1);
    chk("t6_err_clr", loader_error, 1'b0);
    end_dl();
    chk("t6_err_empty", loader_error, 1'b0);

    // Reset during the execute pulse
    start_dl(8'd1);
    send(8'h02); send(8'h02); send(8'hCD); send(8'hAB);
    end_dl();
    chk("t7_xaddr", execute_addr, 16'hABCD);
    tick(); tick(); tick();
    chk("t7_xen_mid", execute_enable, EXEC_ON);
    reset = 1'b1;
    ioctl_wr = 1'b1; ioctl_dout = 8'h5A;
    tick();
    ioctl_wr = 1'b0;
    all_reset_vals("t7_rst");
    reset = 1'b0;
    tick();
    all_reset_vals("t7_post");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
